// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch stage: reset PC, halt word, memory
// address width and the fetch state encoding.
package cpu_defs;

    localparam int          IMEM_AWIDTH = 12;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR  = 32'h0000_000C;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter flop with load enable and a two-way next-PC mux:
// sequential (pc + 4) or an already word-aligned redirect target.
module pc_register #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic                redirect_sel,
    input  logic [PC_WIDTH-1:0] redirect_aligned,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_q;

    // Next PC: hold unless loading; redirect wins over sequential increment.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            if (redirect_sel) begin
                pc_d = redirect_aligned;
            end else begin
                pc_d = pc_q + PC_WIDTH'(4);
            end
        end
    end

    // PC state; reset is asynchronous so the fetch address is valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage. Owns the PC, addresses instruction memory, registers the
// returned word with its PC for decode, and handles redirects, back-pressure
// and halting on syscall.
//
// Handshake: out_* is offered while out_valid is high and is held stable
// until out_ready is seen high on a rising edge; that edge is the transfer.
// out_valid never drops without a transfer except on a redirect (flush).
module instruction_fetch
    import cpu_defs::*;
#(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  IMEM_AWIDTH = cpu_defs::IMEM_AWIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(cpu_defs::RESET_PC),
    parameter logic [31:0]         HALT_INSTR  = cpu_defs::HALT_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [IMEM_AWIDTH-1:0] imem_addr,
    input  logic [31:0]            imem_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [PC_WIDTH-1:0]    out_pc_plus4,
    output logic                   halted,
    output logic                   misalign_fault,
    output logic [31:0]            fetch_count,
    output logic [1:0]             state_dbg
);

    fetch_state_e        state_d, state_q;
    logic                out_valid_d, out_valid_q;
    logic [31:0]         out_instr_d, out_instr_q;
    logic [PC_WIDTH-1:0] out_pc_d, out_pc_q;
    logic [PC_WIDTH-1:0] out_pc_plus4_d, out_pc_plus4_q;
    logic                misalign_d, misalign_q;
    logic [31:0]         fetch_count_d, fetch_count_q;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] redirect_aligned;
    logic                pc_load;
    logic                pc_redirect;
    logic                xfer;
    logic                load;

    assign redirect_aligned = {redirect_target[PC_WIDTH-1:2], 2'b00};
    assign xfer             = out_valid_q && out_ready;
    assign load             = !out_valid_q || out_ready;

    pc_register #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_en          (pc_load),
        .redirect_sel     (pc_redirect),
        .redirect_aligned (redirect_aligned),
        .pc               (pc)
    );

    // Next-state, capture, flush and transfer-count decisions.
    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        fetch_count_d  = fetch_count_q;
        misalign_d     = redirect_valid && (redirect_target[1:0] != 2'b00);
        pc_load        = 1'b0;
        pc_redirect    = 1'b0;

        // A transfer on the same edge as a redirect still completes and counts.
        if (xfer) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
                if (redirect_valid) begin
                    pc_load     = 1'b1;
                    pc_redirect = 1'b1;
                end
            end
            FETCH_RUN: begin
                if (redirect_valid) begin
                    pc_load     = 1'b1;
                    pc_redirect = 1'b1;
                    out_valid_d = 1'b0;
                end else if (load) begin
                    out_instr_d    = imem_data;
                    out_pc_d       = pc;
                    out_pc_plus4_d = pc + PC_WIDTH'(4);
                    out_valid_d    = 1'b1;
                    pc_load        = 1'b1;
                    if (imem_data == HALT_INSTR) begin
                        state_d = FETCH_HALT;
                    end
                end
            end
            FETCH_HALT: begin
                if (redirect_valid) begin
                    pc_load     = 1'b1;
                    pc_redirect = 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = FETCH_RUN;
                end else if (xfer) begin
                    // The halting word drains to decode; nothing new is fetched.
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = FETCH_BOOT;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FETCH_BOOT;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_pc_q       <= '0;
            out_pc_plus4_q <= '0;
            misalign_q     <= 1'b0;
            fetch_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
            misalign_q     <= misalign_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign imem_addr      = pc[IMEM_AWIDTH+1:2];
    assign out_valid      = out_valid_q;
    assign out_instr      = out_instr_q;
    assign out_pc         = out_pc_q;
    assign out_pc_plus4   = out_pc_plus4_q;
    assign halted         = (state_q == FETCH_HALT);
    assign misalign_fault = misalign_q;
    assign fetch_count    = fetch_count_q;
    assign state_dbg      = state_q;

endmodule
